// File: rtl/mem_access.sv
// mem_access: memory-access stage of the main pipeline.
//   Takes the cushion stage outputs, performs loads/stores over a req/ack data
//   memory port, stalls upstream with MMU_WAIT while an access is pending,
//   formats load data and registers one writeback bundle per retired instruction.
// Ports:
//   CLK, RST (sync, active-high), FLUSH
//   CUSHION_*  : instruction from the cushion stage (valid/pc, ALU reg write,
//                CSR write, load, store, jump, exception)
//   MMU_WAIT   : combinational stall to upstream
//   DMEM_*     : registered req/we/addr/strb/wdata out, ack/err/rdata in
//   WB_*       : registered writeback bundle
module mem_access #(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        FLUSH,
   input  logic        CUSHION_VALID,
   input  logic [31:0] CUSHION_PC,
   input  logic        CUSHION_REG_W_EN,
   input  logic [4:0]  CUSHION_REG_W_RD,
   input  logic [31:0] CUSHION_REG_W_DATA,
   input  logic        CUSHION_CSR_W_EN,
   input  logic [11:0] CUSHION_CSR_W_ADDR,
   input  logic [31:0] CUSHION_CSR_W_DATA,
   input  logic        CUSHION_MEM_R_EN,
   input  logic [4:0]  CUSHION_MEM_R_RD,
   input  logic [31:0] CUSHION_MEM_R_ADDR,
   input  logic [3:0]  CUSHION_MEM_R_STRB,
   input  logic        CUSHION_MEM_R_SIGNED,
   input  logic        CUSHION_MEM_W_EN,
   input  logic [31:0] CUSHION_MEM_W_ADDR,
   input  logic [3:0]  CUSHION_MEM_W_STRB,
   input  logic [31:0] CUSHION_MEM_W_DATA,
   input  logic        CUSHION_JMP_DO,
   input  logic [31:0] CUSHION_JMP_PC,
   input  logic        CUSHION_EXC_EN,
   input  logic [3:0]  CUSHION_EXC_CODE,
   output logic        MMU_WAIT,
   output logic        DMEM_REQ,
   output logic        DMEM_WE,
   output logic [31:0] DMEM_ADDR,
   output logic [3:0]  DMEM_STRB,
   output logic [31:0] DMEM_WDATA,
   input  logic        DMEM_ACK,
   input  logic        DMEM_ERR,
   input  logic [31:0] DMEM_RDATA,
   output logic        WB_VALID,
   output logic [31:0] WB_PC,
   output logic        WB_REG_W_EN,
   output logic [4:0]  WB_REG_W_RD,
   output logic [31:0] WB_REG_W_DATA,
   output logic        WB_CSR_W_EN,
   output logic [11:0] WB_CSR_W_ADDR,
   output logic [31:0] WB_CSR_W_DATA,
   output logic        WB_JMP_DO,
   output logic [31:0] WB_JMP_PC,
   output logic        WB_EXC_EN,
   output logic [3:0]  WB_EXC_CODE
);

   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic        reg_w_en;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        csr_w_en;
      logic [11:0] csr_addr;
      logic [31:0] csr_data;
      logic        jmp_do;
      logic [31:0] jmp_pc;
      logic        exc_en;
      logic [3:0]  exc_code;
   } wb_t;

   state_t      state;
   logic        kill;
   logic [31:0] tcnt;
   logic        fault;
   logic [3:0]  fault_code;
   logic        l_ld;
   wb_t         lat;
   logic [31:0] l_ld_addr;
   logic [3:0]  l_ld_strb;
   logic        l_ld_signed;
   logic [31:0] ld_data;
   wb_t         nx;
   wb_t         wb_q;

   logic mem_op, bad_strb, start, tmo_hit, bus_end, bus_fail;

   function automatic logic strb_ok(input logic [3:0] strb);
      case (strb)
         4'b0001, 4'b0010, 4'b0100, 4'b1000,
         4'b0011, 4'b1100, 4'b1111: strb_ok = 1'b1;
         default:                   strb_ok = 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] fmt_load(input logic [3:0] strb,
                                            input logic [31:0] word,
                                            input logic sgn);
      case (strb)
         4'b0001: fmt_load = {{24{sgn & word[7]}},  word[7:0]};
         4'b0010: fmt_load = {{24{sgn & word[15]}}, word[15:8]};
         4'b0100: fmt_load = {{24{sgn & word[23]}}, word[23:16]};
         4'b1000: fmt_load = {{24{sgn & word[31]}}, word[31:24]};
         4'b0011: fmt_load = {{16{sgn & word[15]}}, word[15:0]};
         4'b1100: fmt_load = {{16{sgn & word[31]}}, word[31:16]};
         default: fmt_load = word;
      endcase
   endfunction

   assign mem_op   = CUSHION_VALID & ~CUSHION_EXC_EN & (CUSHION_MEM_R_EN | CUSHION_MEM_W_EN);
   // A load with an illegal strobe becomes a code-4 exception and never reaches the bus.
   assign bad_strb = CUSHION_VALID & ~CUSHION_EXC_EN & CUSHION_MEM_R_EN & ~strb_ok(CUSHION_MEM_R_STRB);
   assign start    = (state == IDLE) & ~FLUSH & mem_op & ~bad_strb;

   assign tmo_hit  = (TIMEOUT_CYCLES != 32'd0) & ~DMEM_ACK & (tcnt == TIMEOUT_CYCLES - 32'd1);
   assign bus_end  = DMEM_ACK | tmo_hit;
   assign bus_fail = (DMEM_ACK & DMEM_ERR) | tmo_hit;

   // Upstream must hold from the cycle the op is seen until the bus completes,
   // including a killed transaction that is still draining.
   assign MMU_WAIT = start | (state == WRITE) | (state == READ);

   // Control FSM and bus-side registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         kill       <= 1'b0;
         tcnt       <= 32'd0;
         fault      <= 1'b0;
         fault_code <= 4'd0;
         l_ld       <= 1'b0;
         DMEM_REQ   <= 1'b0;
         DMEM_WE    <= 1'b0;
         DMEM_ADDR  <= 32'd0;
         DMEM_STRB  <= 4'd0;
         DMEM_WDATA <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               tcnt  <= 32'd0;
               fault <= 1'b0;
               kill  <= 1'b0;
               if (start) begin
                  l_ld     <= CUSHION_MEM_R_EN;
                  DMEM_REQ <= 1'b1;
                  if (CUSHION_MEM_W_EN) begin
                     state      <= WRITE;
                     DMEM_WE    <= 1'b1;
                     DMEM_ADDR  <= CUSHION_MEM_W_ADDR & WORD_MASK;
                     DMEM_STRB  <= CUSHION_MEM_W_STRB;
                     DMEM_WDATA <= CUSHION_MEM_W_DATA;
                  end else begin
                     state      <= READ;
                     DMEM_WE    <= 1'b0;
                     DMEM_ADDR  <= CUSHION_MEM_R_ADDR & WORD_MASK;
                     DMEM_STRB  <= CUSHION_MEM_R_STRB;
                     DMEM_WDATA <= 32'd0;
                  end
               end
            end
            WRITE, READ: begin
               if (FLUSH) kill <= 1'b1;
               if (bus_end) begin
                  tcnt <= 32'd0;
                  if (kill | FLUSH) begin
                     // Killed instruction: the bus completed, drop the result silently.
                     state    <= IDLE;
                     kill     <= 1'b0;
                     DMEM_REQ <= 1'b0;
                  end else if (bus_fail) begin
                     fault      <= 1'b1;
                     fault_code <= (state == WRITE) ? 4'd7 : 4'd5;
                     state      <= DONE;
                     DMEM_REQ   <= 1'b0;
                  end else if ((state == WRITE) && l_ld) begin
                     state      <= READ;
                     DMEM_WE    <= 1'b0;
                     DMEM_ADDR  <= l_ld_addr & WORD_MASK;
                     DMEM_STRB  <= l_ld_strb;
                     DMEM_WDATA <= 32'd0;
                  end else begin
                     state    <= DONE;
                     DMEM_REQ <= 1'b0;
                  end
               end else begin
                  tcnt <= tcnt + 32'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Instruction fields captured when an access starts, plus the formatted load word
   always_ff @(posedge CLK) begin
      if (start) begin
         lat.valid    <= 1'b1;
         lat.pc       <= CUSHION_PC;
         lat.reg_w_en <= CUSHION_MEM_R_EN | CUSHION_REG_W_EN;
         lat.rd       <= CUSHION_MEM_R_EN ? CUSHION_MEM_R_RD : CUSHION_REG_W_RD;
         lat.data     <= CUSHION_REG_W_DATA;
         lat.csr_w_en <= CUSHION_CSR_W_EN;
         lat.csr_addr <= CUSHION_CSR_W_ADDR;
         lat.csr_data <= CUSHION_CSR_W_DATA;
         lat.jmp_do   <= CUSHION_JMP_DO;
         lat.jmp_pc   <= CUSHION_JMP_PC;
         lat.exc_en   <= 1'b0;
         lat.exc_code <= 4'd0;
         l_ld_addr    <= CUSHION_MEM_R_ADDR;
         l_ld_strb    <= CUSHION_MEM_R_STRB;
         l_ld_signed  <= CUSHION_MEM_R_SIGNED;
      end
      if ((state == READ) && DMEM_ACK)
         ld_data <= fmt_load(l_ld_strb, DMEM_RDATA, l_ld_signed);
   end

   // Next writeback bundle: pass-through in IDLE, latched result in DONE, zero otherwise
   always_comb begin
      nx = '0;
      case (state)
         IDLE: begin
            if (!FLUSH && CUSHION_VALID && !start) begin
               nx.valid    = 1'b1;
               nx.pc       = CUSHION_PC;
               nx.reg_w_en = CUSHION_REG_W_EN;
               nx.rd       = CUSHION_REG_W_RD;
               nx.data     = CUSHION_REG_W_DATA;
               nx.csr_w_en = CUSHION_CSR_W_EN;
               nx.csr_addr = CUSHION_CSR_W_ADDR;
               nx.csr_data = CUSHION_CSR_W_DATA;
               nx.jmp_do   = CUSHION_JMP_DO;
               nx.jmp_pc   = CUSHION_JMP_PC;
               nx.exc_en   = CUSHION_EXC_EN;
               nx.exc_code = CUSHION_EXC_CODE;
               if (bad_strb) begin
                  nx.exc_en   = 1'b1;
                  nx.exc_code = 4'd4;
                  nx.reg_w_en = 1'b0;
                  nx.csr_w_en = 1'b0;
                  nx.jmp_do   = 1'b0;
               end
            end
         end
         DONE: begin
            if (!FLUSH) begin
               nx = lat;
               if (l_ld) nx.data = ld_data;
               if (fault) begin
                  nx.exc_en   = 1'b1;
                  nx.exc_code = fault_code;
                  nx.reg_w_en = 1'b0;
                  nx.csr_w_en = 1'b0;
                  nx.jmp_do   = 1'b0;
               end
            end
         end
         default: nx = '0;
      endcase
   end

   // Writeback register stage
   always_ff @(posedge CLK) begin
      if (RST) wb_q <= '0;
      else     wb_q <= nx;
   end

   assign WB_VALID      = wb_q.valid;
   assign WB_PC         = wb_q.pc;
   assign WB_REG_W_EN   = wb_q.reg_w_en;
   assign WB_REG_W_RD   = wb_q.rd;
   assign WB_REG_W_DATA = wb_q.data;
   assign WB_CSR_W_EN   = wb_q.csr_w_en;
   assign WB_CSR_W_ADDR = wb_q.csr_addr;
   assign WB_CSR_W_DATA = wb_q.csr_data;
   assign WB_JMP_DO     = wb_q.jmp_do;
   assign WB_JMP_PC     = wb_q.jmp_pc;
   assign WB_EXC_EN     = wb_q.exc_en;
   assign WB_EXC_CODE   = wb_q.exc_code;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed bench for mem_access (instance built with TIMEOUT_CYCLES=4).
//   Single-cycle pass-through behaviour is driven from a vector table; loads,
//   stores, bus errors, flush-kill, timeout and reset-mid-access are hand sequences.
module tb_mem_access;

   logic        CLK = 1'b0;
   logic        RST, FLUSH;
   logic        CUSHION_VALID;
   logic [31:0] CUSHION_PC;
   logic        CUSHION_REG_W_EN;
   logic [4:0]  CUSHION_REG_W_RD;
   logic [31:0] CUSHION_REG_W_DATA;
   logic        CUSHION_CSR_W_EN;
   logic [11:0] CUSHION_CSR_W_ADDR;
   logic [31:0] CUSHION_CSR_W_DATA;
   logic        CUSHION_MEM_R_EN;
   logic [4:0]  CUSHION_MEM_R_RD;
   logic [31:0] CUSHION_MEM_R_ADDR;
   logic [3:0]  CUSHION_MEM_R_STRB;
   logic        CUSHION_MEM_R_SIGNED;
   logic        CUSHION_MEM_W_EN;
   logic [31:0] CUSHION_MEM_W_ADDR;
   logic [3:0]  CUSHION_MEM_W_STRB;
   logic [31:0] CUSHION_MEM_W_DATA;
   logic        CUSHION_JMP_DO;
   logic [31:0] CUSHION_JMP_PC;
   logic        CUSHION_EXC_EN;
   logic [3:0]  CUSHION_EXC_CODE;
   logic        MMU_WAIT;
   logic        DMEM_REQ, DMEM_WE;
   logic [31:0] DMEM_ADDR;
   logic [3:0]  DMEM_STRB;
   logic [31:0] DMEM_WDATA;
   logic        DMEM_ACK, DMEM_ERR;
   logic [31:0] DMEM_RDATA;
   logic        WB_VALID;
   logic [31:0] WB_PC;
   logic        WB_REG_W_EN;
   logic [4:0]  WB_REG_W_RD;
   logic [31:0] WB_REG_W_DATA;
   logic        WB_CSR_W_EN;
   logic [11:0] WB_CSR_W_ADDR;
   logic [31:0] WB_CSR_W_DATA;
   logic        WB_JMP_DO;
   logic [31:0] WB_JMP_PC;
   logic        WB_EXC_EN;
   logic [3:0]  WB_EXC_CODE;

   always #5 CLK = ~CLK;

   mem_access #(.TIMEOUT_CYCLES(32'd4)) dut (
      .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
      .CUSHION_VALID(CUSHION_VALID), .CUSHION_PC(CUSHION_PC),
      .CUSHION_REG_W_EN(CUSHION_REG_W_EN), .CUSHION_REG_W_RD(CUSHION_REG_W_RD),
      .CUSHION_REG_W_DATA(CUSHION_REG_W_DATA),
      .CUSHION_CSR_W_EN(CUSHION_CSR_W_EN), .CUSHION_CSR_W_ADDR(CUSHION_CSR_W_ADDR),
      .CUSHION_CSR_W_DATA(CUSHION_CSR_W_DATA),
      .CUSHION_MEM_R_EN(CUSHION_MEM_R_EN), .CUSHION_MEM_R_RD(CUSHION_MEM_R_RD),
      .CUSHION_MEM_R_ADDR(CUSHION_MEM_R_ADDR), .CUSHION_MEM_R_STRB(CUSHION_MEM_R_STRB),
      .CUSHION_MEM_R_SIGNED(CUSHION_MEM_R_SIGNED),
      .CUSHION_MEM_W_EN(CUSHION_MEM_W_EN), .CUSHION_MEM_W_ADDR(CUSHION_MEM_W_ADDR),
      .CUSHION_MEM_W_STRB(CUSHION_MEM_W_STRB), .CUSHION_MEM_W_DATA(CUSHION_MEM_W_DATA),
      .CUSHION_JMP_DO(CUSHION_JMP_DO), .CUSHION_JMP_PC(CUSHION_JMP_PC),
      .CUSHION_EXC_EN(CUSHION_EXC_EN), .CUSHION_EXC_CODE(CUSHION_EXC_CODE),
      .MMU_WAIT(MMU_WAIT),
      .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
      .DMEM_STRB(DMEM_STRB), .DMEM_WDATA(DMEM_WDATA),
      .DMEM_ACK(DMEM_ACK), .DMEM_ERR(DMEM_ERR), .DMEM_RDATA(DMEM_RDATA),
      .WB_VALID(WB_VALID), .WB_PC(WB_PC),
      .WB_REG_W_EN(WB_REG_W_EN), .WB_REG_W_RD(WB_REG_W_RD), .WB_REG_W_DATA(WB_REG_W_DATA),
      .WB_CSR_W_EN(WB_CSR_W_EN), .WB_CSR_W_ADDR(WB_CSR_W_ADDR), .WB_CSR_W_DATA(WB_CSR_W_DATA),
      .WB_JMP_DO(WB_JMP_DO), .WB_JMP_PC(WB_JMP_PC),
      .WB_EXC_EN(WB_EXC_EN), .WB_EXC_CODE(WB_EXC_CODE)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      FLUSH = 1'b0;
      CUSHION_VALID = 1'b0;        CUSHION_PC = 32'h0;
      CUSHION_REG_W_EN = 1'b0;     CUSHION_REG_W_RD = 5'd0;   CUSHION_REG_W_DATA = 32'h0;
      CUSHION_CSR_W_EN = 1'b0;     CUSHION_CSR_W_ADDR = 12'h0; CUSHION_CSR_W_DATA = 32'h0;
      CUSHION_MEM_R_EN = 1'b0;     CUSHION_MEM_R_RD = 5'd0;   CUSHION_MEM_R_ADDR = 32'h0;
      CUSHION_MEM_R_STRB = 4'h0;   CUSHION_MEM_R_SIGNED = 1'b0;
      CUSHION_MEM_W_EN = 1'b0;     CUSHION_MEM_W_ADDR = 32'h0;
      CUSHION_MEM_W_STRB = 4'h0;   CUSHION_MEM_W_DATA = 32'h0;
      CUSHION_JMP_DO = 1'b0;       CUSHION_JMP_PC = 32'h0;
      CUSHION_EXC_EN = 1'b0;       CUSHION_EXC_CODE = 4'h0;
      DMEM_ACK = 1'b0;             DMEM_ERR = 1'b0;           DMEM_RDATA = 32'h0;
   endtask

   typedef struct {
      logic        valid;
      logic        flush;
      logic        reg_w_en;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        csr_w_en;
      logic        mem_r_en;
      logic [3:0]  strb;
      logic        jmp_do;
      logic        exc_en;
      logic [3:0]  exc_code;
      logic        e_valid;
      logic        e_reg_w_en;
      logic [4:0]  e_rd;
      logic [31:0] e_data;
      logic        e_csr_w_en;
      logic        e_jmp_do;
      logic        e_exc_en;
      logic [3:0]  e_exc_code;
      logic        e_wait;
   } vec_t;

   vec_t vecs[8];

   task automatic apply_vec(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      clear_inputs();
      CUSHION_VALID = v.valid;       FLUSH = v.flush;
      CUSHION_PC = 32'h100;
      CUSHION_REG_W_EN = v.reg_w_en; CUSHION_REG_W_RD = v.rd; CUSHION_REG_W_DATA = v.data;
      CUSHION_CSR_W_EN = v.csr_w_en; CUSHION_CSR_W_ADDR = 12'h300; CUSHION_CSR_W_DATA = 32'hCAFE0000;
      CUSHION_MEM_R_EN = v.mem_r_en; CUSHION_MEM_R_RD = 5'd17;
      CUSHION_MEM_R_ADDR = 32'h40;   CUSHION_MEM_R_STRB = v.strb;
      CUSHION_JMP_DO = v.jmp_do;     CUSHION_JMP_PC = 32'h80;
      CUSHION_EXC_EN = v.exc_en;     CUSHION_EXC_CODE = v.exc_code;
      @(negedge CLK);
      chk({tag, "_mmu_wait"}, 32'(MMU_WAIT), 32'(v.e_wait));
      @(posedge CLK); #1;
      chk({tag, "_wb_valid"}, 32'(WB_VALID), 32'(v.e_valid));
      chk({tag, "_wb_pc"}, WB_PC, v.e_valid ? 32'h100 : 32'h0);
      chk({tag, "_wb_reg_w_en"}, 32'(WB_REG_W_EN), 32'(v.e_reg_w_en));
      chk({tag, "_wb_rd"}, 32'(WB_REG_W_RD), 32'(v.e_rd));
      chk({tag, "_wb_data"}, WB_REG_W_DATA, v.e_data);
      chk({tag, "_wb_csr_w_en"}, 32'(WB_CSR_W_EN), 32'(v.e_csr_w_en));
      chk({tag, "_wb_jmp_do"}, 32'(WB_JMP_DO), 32'(v.e_jmp_do));
      chk({tag, "_wb_exc_en"}, 32'(WB_EXC_EN), 32'(v.e_exc_en));
      chk({tag, "_wb_exc_code"}, 32'(WB_EXC_CODE), 32'(v.e_exc_code));
      chk({tag, "_dmem_req"}, 32'(DMEM_REQ), 32'h0);
   endtask

   // Results of the last run_access
   int          n_req, n_wait;
   logic        wb_seen;
   logic [31:0] cap_addr, cap_wdata;
   logic [3:0]  cap_strb;
   logic        cap_we;

   // Plays the memory side of one access. ACK (with ERR/RDATA) is returned on
   // the ack_on-th REQ cycle (0 = never); FLUSH is pulsed on the flush_at-th
   // stall cycle (0 = never). Returns at the first cycle with MMU_WAIT low.
   task automatic run_access(input int ack_on, input logic err, input logic [31:0] rdata,
                             input int flush_at, input string tag);
      logic done;
      done = 1'b0;
      n_req = 0; n_wait = 0; wb_seen = 1'b0;
      cap_addr = 32'h0; cap_wdata = 32'h0; cap_strb = 4'h0; cap_we = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (i > 0 && WB_VALID) wb_seen = 1'b1;
         if (!MMU_WAIT) begin
            done = 1'b1;
            break;
         end
         n_wait++;
         if (DMEM_REQ) begin
            n_req++;
            if (n_req == 1) begin
               cap_addr = DMEM_ADDR; cap_strb = DMEM_STRB;
               cap_we = DMEM_WE;     cap_wdata = DMEM_WDATA;
            end
            if (n_req == ack_on) begin
               DMEM_ACK = 1'b1; DMEM_ERR = err; DMEM_RDATA = rdata;
            end
         end
         if (n_wait == flush_at) begin
            FLUSH = 1'b1;
            CUSHION_VALID = 1'b0;
         end
         @(posedge CLK); #1;
         DMEM_ACK = 1'b0; DMEM_ERR = 1'b0; FLUSH = 1'b0;
      end
      chk({tag, "_completed_within_bound"}, 32'(done), 32'h1);
      @(posedge CLK); #1;
   endtask

   initial begin
      //        valid flush  rwen  rd     data          csr   mren  strb     jmp   exc   code  | e_valid e_rwen e_rd  e_data        e_csr e_jmp e_exc e_code e_wait
      vecs[0] = '{1'b1, 1'b0, 1'b1, 5'd5,  32'h0000_1234, 1'b0, 1'b0, 4'h0,    1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 5'd5,  32'h0000_1234, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 1'b1, 5'd9,  32'h0000_FFFF, 1'b1, 1'b1, 4'hF,    1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 1'b1, 5'd6,  32'h0000_0077, 1'b0, 1'b1, 4'hF,    1'b0, 1'b1, 4'd2, 1'b1, 1'b1, 5'd6,  32'h0000_0077, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 5'd8,  32'h0000_0099, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 5'd8,  32'h0000_0099, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 4'h0,    1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
      vecs[5] = '{1'b1, 1'b1, 1'b1, 5'd5,  32'h0000_0055, 1'b0, 1'b0, 4'h0,    1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 1'b1, 5'd1,  32'h0000_0104, 1'b0, 1'b0, 4'h0,    1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 5'd1,  32'h0000_0104, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 1'b0, 5'd2,  32'h0000_0000, 1'b0, 1'b1, 4'b0101, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 5'd2,  32'h0000_0000, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0};

      clear_inputs();
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      chk("reset_mmu_wait", 32'(MMU_WAIT), 32'h0);
      chk("reset_dmem_req", 32'(DMEM_REQ), 32'h0);
      chk("reset_dmem_addr", DMEM_ADDR, 32'h0);
      chk("reset_wb_valid", 32'(WB_VALID), 32'h0);
      chk("reset_wb_data", WB_REG_W_DATA, 32'h0);
      chk("reset_wb_exc_en", 32'(WB_EXC_EN), 32'h0);
      RST = 1'b0;

      for (int i = 0; i < 8; i++) apply_vec(vecs[i], i);

      // LB signed, byte lane 3, ACK on third REQ cycle
      clear_inputs();
      CUSHION_VALID = 1'b1; CUSHION_PC = 32'h200;
      CUSHION_MEM_R_EN = 1'b1; CUSHION_MEM_R_RD = 5'd7;
      CUSHION_MEM_R_ADDR = 32'h1003; CUSHION_MEM_R_STRB = 4'b1000; CUSHION_MEM_R_SIGNED = 1'b1;
      run_access(3, 1'b0, 32'h80AA_BBCC, 0, "lb");
      chk("lb_wait_cycles", 32'(n_wait), 32'd4);
      chk("lb_req_cycles", 32'(n_req), 32'd3);
      chk("lb_dmem_addr", cap_addr, 32'h1000);
      chk("lb_dmem_strb", 32'(cap_strb), 32'h8);
      chk("lb_dmem_we", 32'(cap_we), 32'h0);
      chk("lb_wb_not_early", 32'(wb_seen), 32'h0);
      chk("lb_wb_valid", 32'(WB_VALID), 32'h1);
      chk("lb_wb_pc", WB_PC, 32'h200);
      chk("lb_wb_reg_w_en", 32'(WB_REG_W_EN), 32'h1);
      chk("lb_wb_rd", 32'(WB_REG_W_RD), 32'd7);
      chk("lb_wb_data", WB_REG_W_DATA, 32'hFFFF_FF80);
      chk("lb_wb_exc_en", 32'(WB_EXC_EN), 32'h0);
      clear_inputs();
      @(posedge CLK); #1;
      chk("lb_wb_single_pulse", 32'(WB_VALID), 32'h0);

      // LHU, upper halfword, immediate ACK
      clear_inputs();
      CUSHION_VALID = 1'b1; CUSHION_PC = 32'h204;
      CUSHION_MEM_R_EN = 1'b1; CUSHION_MEM_R_RD = 5'd10;
      CUSHION_MEM_R_ADDR = 32'h2002; CUSHION_MEM_R_STRB = 4'b1100; CUSHION_MEM_R_SIGNED = 1'b0;
      run_access(1, 1'b0, 32'hBEEF_1234, 0, "lhu");
      chk("lhu_wait_cycles", 32'(n_wait), 32'd2);
      chk("lhu_dmem_addr", cap_addr, 32'h2000);
      chk("lhu_wb_rd", 32'(WB_REG_W_RD), 32'd10);
      chk("lhu_wb_data", WB_REG_W_DATA, 32'h0000_BEEF);
      clear_inputs();

      // SW with bus error
      CUSHION_VALID = 1'b1; CUSHION_PC = 32'h208;
      CUSHION_REG_W_EN = 1'b1; CUSHION_REG_W_RD = 5'd4; CUSHION_REG_W_DATA = 32'h44;
      CUSHION_MEM_W_EN = 1'b1; CUSHION_MEM_W_ADDR = 32'h3004;
      CUSHION_MEM_W_STRB = 4'hF; CUSHION_MEM_W_DATA = 32'hDEAD_BEEF;
      run_access(1, 1'b1, 32'h0, 0, "sw_err");
      chk("sw_err_req_cycles", 32'(n_req), 32'd1);
      chk("sw_err_dmem_we", 32'(cap_we), 32'h1);
      chk("sw_err_dmem_wdata", cap_wdata, 32'hDEAD_BEEF);
      chk("sw_err_dmem_addr", cap_addr, 32'h3004);
      chk("sw_err_wb_valid", 32'(WB_VALID), 32'h1);
      chk("sw_err_wb_exc_en", 32'(WB_EXC_EN), 32'h1);
      chk("sw_err_wb_exc_code", 32'(WB_EXC_CODE), 32'd7);
      chk("sw_err_wb_reg_w_en", 32'(WB_REG_W_EN), 32'h0);
      clear_inputs();

      // SW success: register write fields pass through
      CUSHION_VALID = 1'b1; CUSHION_PC = 32'h20C;
      CUSHION_REG_W_EN = 1'b1; CUSHION_REG_W_RD = 5'd3; CUSHION_REG_W_DATA = 32'h55;
      CUSHION_MEM_W_EN = 1'b1; CUSHION_MEM_W_ADDR = 32'h3008;
      CUSHION_MEM_W_STRB = 4'b0011; CUSHION_MEM_W_DATA = 32'h1122_3344;
      run_access(2, 1'b0, 32'h0, 0, "sw");
      chk("sw_req_cycles", 32'(n_req), 32'd2);
      chk("sw_dmem_strb", 32'(cap_strb), 32'h3);
      chk("sw_wb_reg_w_en", 32'(WB_REG_W_EN), 32'h1);
      chk("sw_wb_rd", 32'(WB_REG_W_RD), 32'd3);
      chk("sw_wb_data", WB_REG_W_DATA, 32'h55);
      chk("sw_wb_exc_en", 32'(WB_EXC_EN), 32'h0);
      clear_inputs();

      // FLUSH while a load is waiting: bus still completes, nothing retires
      CUSHION_VALID = 1'b1; CUSHION_PC = 32'h210;
      CUSHION_MEM_R_EN = 1'b1; CUSHION_MEM_R_RD = 5'd12;
      CUSHION_MEM_R_ADDR = 32'h4000; CUSHION_MEM_R_STRB = 4'hF;
      run_access(3, 1'b0, 32'h1234_5678, 3, "flush");
      chk("flush_req_cycles", 32'(n_req), 32'd3);
      chk("flush_wait_cycles", 32'(n_wait), 32'd4);
      chk("flush_wb_never_valid", 32'(wb_seen), 32'h0);
      chk("flush_wb_valid_after", 32'(WB_VALID), 32'h0);
      chk("flush_req_dropped", 32'(DMEM_REQ), 32'h0);
      clear_inputs();

      // No ACK: timeout after 4 REQ cycles reports a load fault
      CUSHION_VALID = 1'b1; CUSHION_PC = 32'h214;
      CUSHION_MEM_R_EN = 1'b1; CUSHION_MEM_R_RD = 5'd13;
      CUSHION_MEM_R_ADDR = 32'h5000; CUSHION_MEM_R_STRB = 4'hF;
      run_access(0, 1'b0, 32'h0, 0, "tmo");
      chk("tmo_req_cycles", 32'(n_req), 32'd4);
      chk("tmo_wb_valid", 32'(WB_VALID), 32'h1);
      chk("tmo_wb_exc_en", 32'(WB_EXC_EN), 32'h1);
      chk("tmo_wb_exc_code", 32'(WB_EXC_CODE), 32'd5);
      chk("tmo_wb_reg_w_en", 32'(WB_REG_W_EN), 32'h0);
      clear_inputs();

      // Reset in the middle of an access
      CUSHION_VALID = 1'b1; CUSHION_PC = 32'h218;
      CUSHION_MEM_R_EN = 1'b1; CUSHION_MEM_R_ADDR = 32'h6000; CUSHION_MEM_R_STRB = 4'hF;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_mid_req_active", 32'(DMEM_REQ), 32'h1);
      RST = 1'b1;
      clear_inputs();
      @(posedge CLK); #1;
      RST = 1'b0;
      chk("rst_mid_req_dropped", 32'(DMEM_REQ), 32'h0);
      chk("rst_mid_mmu_wait", 32'(MMU_WAIT), 32'h0);
      chk("rst_mid_wb_valid", 32'(WB_VALID), 32'h0);

      apply_vec(vecs[0], 8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
